// File: rtl/rgs_bus_init_pkg.sv
// Shared encodings for the rgs bus initiator: command ops, FSM states and rgs register map.
package rgs_bus_init_pkg;

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_POLL = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_WAIT,
        ST_GAP,
        ST_RESP
    } state_e;

    localparam logic [7:0] REG_RTC_CTRL = 8'h00;
    localparam logic [7:0] REG_TIME_B0  = 8'h40;
    localparam logic [7:0] REG_TIME_B1  = 8'h44;
    localparam logic [7:0] REG_TIME_B2  = 8'h48;
    localparam logic [7:0] REG_TIME_B3  = 8'h4C;
    localparam logic [7:0] REG_TSU_CTRL = 8'h50;
    localparam logic [7:0] REG_RXQ_STAT = 8'h54;
    localparam logic [7:0] REG_TXQ_STAT = 8'h58;

    function automatic logic poll_match(input logic [31:0] rdata,
                                        input logic [31:0] match,
                                        input logic [31:0] mask);
        return ((rdata & mask) == (match & mask));
    endfunction

endpackage

// File: rtl/rgs_bus_init_if.sv
// Command/response and register-bus signals of the rgs bus initiator.
interface rgs_bus_init_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [15:0] rsp_cnt;
    logic        busy;
    logic        wr_out;
    logic        rd_out;
    logic [7:0]  addr_out;
    logic [31:0] wdata_out;
    logic [31:0] bus_rdata;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, bus_rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_cnt, busy,
               wr_out, rd_out, addr_out, wdata_out
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, bus_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_cnt, busy,
               wr_out, rd_out, addr_out, wdata_out
    );
endinterface

// File: rtl/rgs_bus_init.sv
// Single-command rgs bus initiator (write/read/poll). Write responds 2 cycles after accept,
// read 2+RD_LAT; one command in flight, cmd_ready low while busy, responses never stall.
module rgs_bus_init
    import rgs_bus_init_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int POLL_MAX = 1023,
    parameter int POLL_GAP = 4
) (
    input  logic clk,
    input  logic rst,
    rgs_bus_init_if.slave bif
);

    localparam logic [2:0]  LAT_LAST = 3'(RD_LAT - 1);
    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
    localparam logic [15:0] CNT_MAX  = 16'(POLL_MAX);

    state_e      state_q;
    logic [1:0]  op_q;
    logic [31:0] mask_q;
    logic [15:0] rd_cnt_q;
    logic [15:0] rd_cnt_d;
    logic [2:0]  lat_q;
    logic [15:0] gap_q;

    logic        cmd_ready_q;
    logic        busy_q;
    logic        wr_q;
    logic        rd_q;
    logic        rsp_valid_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic [15:0] rsp_cnt_q;

    assign rd_cnt_d = rd_cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'b00;
            mask_q      <= '0;
            rd_cnt_q    <= '0;
            lat_q       <= '0;
            gap_q       <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_cnt_q   <= '0;
        end else begin
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bif.cmd_valid && cmd_ready_q) begin
                        op_q        <= bif.cmd_op;
                        addr_q      <= bif.cmd_addr;
                        wdata_q     <= bif.cmd_data;
                        mask_q      <= bif.cmd_mask;
                        rd_cnt_q    <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        case (bif.cmd_op)
                            OP_WR: begin
                                state_q <= ST_WR;
                                wr_q    <= 1'b1;
                            end
                            OP_RD, OP_POLL: begin
                                state_q <= ST_RD;
                                rd_q    <= 1'b1;
                            end
                            default: begin
                                state_q     <= ST_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b1;
                                rsp_data_q  <= '0;
                                rsp_cnt_q   <= '0;
                            end
                        endcase
                    end else begin
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                ST_WR: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                    rsp_cnt_q   <= '0;
                end
                ST_RD: begin
                    state_q <= ST_WAIT;
                    lat_q   <= '0;
                end
                ST_WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        rd_cnt_q <= rd_cnt_d;
                        // A match on the final attempt wins over the timeout.
                        if (op_q != OP_POLL || poll_match(bif.bus_rdata, wdata_q, mask_q)) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= bif.bus_rdata;
                            rsp_cnt_q   <= rd_cnt_d;
                        end else if (rd_cnt_d == CNT_MAX) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= bif.bus_rdata;
                            rsp_cnt_q   <= rd_cnt_d;
                        end else if (POLL_GAP == 0) begin
                            state_q <= ST_RD;
                            rd_q    <= 1'b1;
                        end else begin
                            state_q <= ST_GAP;
                            gap_q   <= '0;
                        end
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= ST_RD;
                        rd_q    <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bif.cmd_ready = cmd_ready_q;
    assign bif.busy      = busy_q;
    assign bif.wr_out    = wr_q;
    assign bif.rd_out    = rd_q;
    assign bif.rsp_valid = rsp_valid_q;
    assign bif.addr_out  = addr_q;
    assign bif.wdata_out = wdata_q;
    assign bif.rsp_data  = rsp_data_q;
    assign bif.rsp_err   = rsp_err_q;
    assign bif.rsp_cnt   = rsp_cnt_q;

endmodule
